// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer.
//  - seq_state_t : sequencer steps WAIT_A -> WAIT_B -> WAIT_OP -> EVAL -> SHOW_RES
//  - OP_*        : opcode encodings understood by the shared ALU
//  - F_*         : bit positions inside the 5-bit ALU flag vector {N,Z,C,V,P}
//  - state_onehot: maps a state to the 4-bit step LED pattern (EVAL shows nothing)
package alu_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EVAL,
    SHOW_RES
  } seq_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int F_N = 4;
  localparam int F_Z = 3;
  localparam int F_C = 2;
  localparam int F_V = 1;
  localparam int F_P = 0;

  // LED order is {SHOW_RES, WAIT_OP, WAIT_B, WAIT_A}; EVAL is a one-cycle
  // transient and deliberately lights nothing.
  function automatic logic [3:0] state_onehot(input seq_state_t s);
    case (s)
      WAIT_A:   state_onehot = 4'b0001;
      WAIT_B:   state_onehot = 4'b0010;
      WAIT_OP:  state_onehot = 4'b0100;
      SHOW_RES: state_onehot = 4'b1000;
      default:  state_onehot = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// Level-to-pulse converter: emits a single-cycle pulse on each rising edge of
// a debounced button level.
// Ports:
//  clock  in  system clock
//  reset  in  synchronous, active-high
//  level  in  debounced button level
//  pulse  out high for one cycle when level goes 0 -> 1
// The previous-level register resets to 1 so that a button already held down
// when reset is released does not produce a spurious pulse.
module rise_pulse (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequences a shared combinational ALU from one switch bank and one button.
// The user enters A, then B, then the opcode; the block drives the ALU,
// latches result and flags, and shows the result until the next action.
// Parameters:
//  N         operand/result width
//  IDLE_MAX  cycles without a button pulse before SHOW_RES falls back to
//            WAIT_A (0 disables the timeout)
// Ports:
//  clock, reset           system clock, synchronous active-high reset
//  enter, undo            debounced button levels (rising edge = action)
//  data_in [N]            operand switches
//  op_in [2]              opcode switches
//  alu_a, alu_b, alu_op   registered ALU operands/opcode
//  alu_result, alu_flags  combinational ALU outputs {N,Z,C,V,P}
//  disp_value [N]         value for the hex display
//  flags_out [5]          latched flags, meaningful in SHOW_RES
//  state_led [4]          one-hot step {SHOW_RES,WAIT_OP,WAIT_B,WAIT_A}
//  result_vld             high while in SHOW_RES
// Build option: define ALU_SEQ_CHAIN_EN to make enter in SHOW_RES load the
// result into A and continue at WAIT_B (accumulator chaining). Without it,
// enter in SHOW_RES returns to WAIT_A and keeps the operand registers.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N        = 7,
  parameter int IDLE_MAX = 5000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enter,
  input  logic         undo,
  input  logic [N-1:0] data_in,
  input  logic [1:0]   op_in,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [N-1:0] disp_value,
  output logic [4:0]   flags_out,
  output logic [3:0]   state_led,
  output logic         result_vld
);

  localparam int CNT_W = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'((IDLE_MAX > 0) ? IDLE_MAX - 1 : 0);

  seq_state_t state, next_state;
  logic       enter_p, undo_p;
  logic [N-1:0] result;
  logic [CNT_W-1:0] idle_cnt;
  logic idle_hit;
  logic load_a, load_a_res, load_b, load_op, load_res;

  rise_pulse u_enter_edge (
    .clock (clock),
    .reset (reset),
    .level (enter),
    .pulse (enter_p)
  );

  rise_pulse u_undo_edge (
    .clock (clock),
    .reset (reset),
    .level (undo),
    .pulse (undo_p)
  );

  assign idle_hit = (IDLE_MAX != 0) && (idle_cnt == IDLE_LIM);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; undo always takes priority over a simultaneous enter.
  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_a_res = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    case (state)
      WAIT_A: begin
        if (enter_p && !undo_p) begin
          load_a     = 1'b1;
          next_state = WAIT_B;
        end
      end
      WAIT_B: begin
        if (undo_p) begin
          next_state = WAIT_A;
        end else if (enter_p) begin
          load_b     = 1'b1;
          next_state = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (undo_p) begin
          next_state = WAIT_B;
        end else if (enter_p) begin
          load_op    = 1'b1;
          next_state = EVAL;
        end
      end
      EVAL: begin
        // Operands and opcode have been stable for a full cycle here.
        load_res   = 1'b1;
        next_state = SHOW_RES;
      end
      SHOW_RES: begin
        if (undo_p) begin
          next_state = WAIT_OP;
        end else if (enter_p) begin
`ifdef ALU_SEQ_CHAIN_EN
          load_a_res = 1'b1;
          next_state = WAIT_B;
`else
          next_state = WAIT_A;
`endif
        end else if (idle_hit) begin
          next_state = WAIT_A;
        end
      end
      default: next_state = WAIT_A;
    endcase
  end

  // Output logic: everything is decoded from registered state.
  always_comb begin
    state_led  = state_onehot(state);
    result_vld = (state == SHOW_RES);
    case (state)
      WAIT_A, WAIT_B: disp_value = data_in;
      SHOW_RES:       disp_value = result;
      default:        disp_value = alu_b;
    endcase
  end

  // Operand, opcode and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      result    <= '0;
      flags_out <= '0;
    end else begin
      if (load_a) begin
        alu_a <= data_in;
      end else if (load_a_res) begin
        alu_a <= result;
      end
      if (load_b) begin
        alu_b <= data_in;
      end
      if (load_op) begin
        alu_op <= op_in;
      end
      if (load_res) begin
        result    <= alu_result;
        flags_out <= alu_flags;
      end
    end
  end

  // Idle counter: runs only while staying in SHOW_RES with no button
  // activity, and saturates at the timeout value instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state != SHOW_RES || next_state != SHOW_RES || enter_p || undo_p) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LIM) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small ALU attached.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int N = 7;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enter = 1'b0;
  logic         undo  = 1'b0;
  logic [N-1:0] data_in = '0;
  logic [1:0]   op_in = 2'b00;
  logic [N-1:0] alu_a, alu_b, alu_result, disp_value;
  logic [1:0]   alu_op;
  logic [4:0]   alu_flags, flags_out;
  logic [3:0]   state_led;
  logic         result_vld;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_operand_sequencer #(.N(N), .IDLE_MAX(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .enter      (enter),
    .undo       (undo),
    .data_in    (data_in),
    .op_in      (op_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .disp_value (disp_value),
    .flags_out  (flags_out),
    .state_led  (state_led),
    .result_vld (result_vld)
  );

  always #5 clock = ~clock;

  // Bench ALU: C is carry-out for ADD and borrow for SUB.
  always_comb begin
    logic [N-1:0] r;
    logic c, v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        {c, r} = {1'b0, alu_a} + {1'b0, alu_b};
        v = (alu_a[N-1] == alu_b[N-1]) && (r[N-1] != alu_a[N-1]);
      end
      OP_SUB: begin
        r = alu_a - alu_b;
        c = (alu_a < alu_b);
        v = (alu_a[N-1] != alu_b[N-1]) && (r[N-1] != alu_a[N-1]);
      end
      OP_OR:   r = alu_a | alu_b;
      default: r = alu_a & alu_b;
    endcase
    alu_result = r;
    alu_flags  = {r[N-1], (r == '0), c, v, ^r};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press_enter();
    @(negedge clock) enter = 1'b1;
    @(negedge clock) enter = 1'b0;
  endtask

  task automatic press_undo();
    @(negedge clock) undo = 1'b1;
    @(negedge clock) undo = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask

  // Leaves the DUT in EVAL at the returned falling edge.
  task automatic run_seq(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
    data_in = a;
    press_enter();
    data_in = b;
    press_enter();
    op_in = op;
    press_enter();
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic [N-1:0] res;
    logic [4:0]   flg;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // {a, b, op, result, flags {N,Z,C,V,P}} -- all hand computed for N=7
    vecs[0] = '{7'd25, 7'd17, OP_ADD, 7'd42,  5'b00001};
    vecs[1] = '{7'd5,  7'd5,  OP_SUB, 7'd0,   5'b01000};
    vecs[2] = '{7'd100, 7'd50, OP_ADD, 7'd22, 5'b00101};
    vecs[3] = '{7'd85, 7'd42, OP_OR,  7'd127, 5'b10001};
    vecs[4] = '{7'd85, 7'd42, OP_AND, 7'd0,   5'b01000};
    vecs[5] = '{7'd3,  7'd5,  OP_SUB, 7'd126, 5'b10100};

    // Reset held for three cycles
    repeat (3) @(negedge clock);
    chk("rst_led", state_led, 4'b0001);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_disp", disp_value, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_vld", result_vld, 0);
    reset = 1'b0;

    // Table of full A/B/op sequences
    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("v%0d_eval_led", i), state_led, 4'b0000);
      chk($sformatf("v%0d_eval_vld", i), result_vld, 0);
      @(negedge clock);
      chk($sformatf("v%0d_vld", i), result_vld, 1);
      chk($sformatf("v%0d_led", i), state_led, 4'b1000);
      chk($sformatf("v%0d_disp", i), disp_value, vecs[i].res);
      chk($sformatf("v%0d_flags", i), flags_out, vecs[i].flg);
      chk($sformatf("v%0d_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d_b", i), alu_b, vecs[i].b);
      chk($sformatf("v%0d_op", i), alu_op, vecs[i].op);
      do_reset();
    end

    // Enter held for 10 cycles advances exactly one step
    data_in = 7'd9;
    @(negedge clock) enter = 1'b1;
    repeat (10) @(negedge clock);
    enter = 1'b0;
    chk("hold_led", state_led, 4'b0010);
    chk("hold_a", alu_a, 9);

    // WAIT_OP shows B; undo+enter together goes back, opcode not loaded
    data_in = 7'd11;
    press_enter();
    data_in = 7'd99;
    chk("wop_led", state_led, 4'b0100);
    chk("wop_disp", disp_value, 11);
    op_in = OP_SUB;
    @(negedge clock) begin enter = 1'b1; undo = 1'b1; end
    @(negedge clock) begin enter = 1'b0; undo = 1'b0; end
    chk("both_led", state_led, 4'b0010);
    chk("both_op", alu_op, OP_ADD);
    press_undo();
    chk("undo_b_led", state_led, 4'b0001);
    chk("undo_b_a", alu_a, 9);
    press_undo();
    chk("undo_a_led", state_led, 4'b0001);
    chk("undo_a_a", alu_a, 9);

    // Chaining from SHOW_RES
    do_reset();
    run_seq(7'd10, 7'd20, OP_ADD);
    @(negedge clock);
    chk("chain_first", disp_value, 30);
    press_enter();
`ifdef ALU_SEQ_CHAIN_EN
    chk("chain_led", state_led, 4'b0010);
    chk("chain_a", alu_a, 30);
    data_in = 7'd3;
    press_enter();
    op_in = OP_ADD;
    press_enter();
    @(negedge clock);
    chk("chain_res", disp_value, 33);
`else
    chk("nochain_led", state_led, 4'b0001);
    chk("nochain_a", alu_a, 10);
`endif

    // Undo in SHOW_RES, then idle timeout
    do_reset();
    run_seq(7'd1, 7'd2, OP_ADD);
    @(negedge clock);
    press_undo();
    chk("undo_show_led", state_led, 4'b0100);
    op_in = OP_OR;
    press_enter();
    @(negedge clock);
    chk("idle_entry_disp", disp_value, 3);
    repeat (19) @(negedge clock);
    chk("idle_19_led", state_led, 4'b1000);
    @(negedge clock);
    chk("idle_20_led", state_led, 4'b0001);
    chk("idle_keep_a", alu_a, 1);
    chk("idle_keep_op", alu_op, OP_OR);

    // Reset while in EVAL
    do_reset();
    run_seq(7'd4, 7'd4, OP_ADD);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_eval_led", state_led, 4'b0001);
    chk("rst_eval_vld", result_vld, 0);
    chk("rst_eval_a", alu_a, 0);
    reset = 1'b0;

    // Button held through reset release gives no pulse
    @(negedge clock) begin reset = 1'b1; enter = 1'b1; end
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("held_rst_led", state_led, 4'b0001);
    enter = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
